// File: rtl/fp_pkg.sv
// Shared definitions for the FP adder arbiter: data width, FSM encoding and
// IEEE-754 single-precision constants.
package fp_pkg;

  localparam int unsigned FP_W = 32;

  // IEEE-754 single-precision values.
  localparam logic [31:0] FP_ONE   = 32'h3F80_0000;
  localparam logic [31:0] FP_TWO   = 32'h4000_0000;
  localparam logic [31:0] FP_THREE = 32'h4040_0000;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StSend  = 2'd1,
    StWaitZ = 2'd2,
    StResp  = 2'd3
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: returns the first asserted request found
// when searching cyclically upward from ptr.
module rr_arbiter
  import fp_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   ptr,
  output logic [IDW-1:0]   grant,
  output logic             any_req
);

  // Walk offsets from farthest to nearest so the nearest hit to ptr wins.
  always_comb begin
    int unsigned idx;
    grant   = '0;
    any_req = 1'b0;
    idx     = 0;
    for (int off = int'(N_REQ) - 1; off >= 0; off--) begin
      idx = (32'(ptr) + unsigned'(off)) % N_REQ;
      if (req[idx[IDW-1:0]]) begin
        grant   = IDW'(idx);
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_adder_arbiter.sv
// Shares one stb/ack single-precision adder among N_REQ requesters. One
// operation at a time: capture operands, hand them to the adder, collect z,
// return it to the same requester, then rotate priority past it.
module fp_adder_arbiter
  import fp_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_stb,
  output logic [N_REQ-1:0]      req_ack,
  input  logic [FP_W*N_REQ-1:0] req_a,
  input  logic [FP_W*N_REQ-1:0] req_b,
  output logic [N_REQ-1:0]      resp_stb,
  input  logic [N_REQ-1:0]      resp_ack,
  output logic [FP_W-1:0]       resp_z,
  output logic [FP_W-1:0]       add_a,
  output logic                  add_a_stb,
  input  logic                  add_a_ack,
  output logic [FP_W-1:0]       add_b,
  output logic                  add_b_stb,
  input  logic                  add_b_ack,
  input  logic [FP_W-1:0]       add_z,
  input  logic                  add_z_stb,
  output logic                  add_z_ack,
  output logic                  busy,
  output logic [IDW-1:0]        grant_id
);

  state_e          state;
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  pick;
  logic            any_req;
  logic            a_done;
  logic            b_done;
  logic [IDW-1:0]  next_ptr;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDW   (IDW)
  ) u_rr (
    .req     (req_stb),
    .ptr     (ptr),
    .grant   (pick),
    .any_req (any_req)
  );

  // An operand side is done once its stb is low or its ack arrives this cycle.
  always_comb begin
    a_done   = !add_a_stb || add_a_ack;
    b_done   = !add_b_stb || add_b_ack;
    next_ptr = (grant_id == IDW'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
  end

  // Control FSM; every handshake output is registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= StIdle;
      ptr       <= '0;
      grant_id  <= '0;
      req_ack   <= '0;
      resp_stb  <= '0;
      resp_z    <= '0;
      add_a     <= '0;
      add_b     <= '0;
      add_a_stb <= 1'b0;
      add_b_stb <= 1'b0;
      add_z_ack <= 1'b0;
      busy      <= 1'b0;
    end else begin
      req_ack   <= '0;
      add_z_ack <= 1'b0;
      case (state)
        StIdle: begin
          if (any_req) begin
            grant_id  <= pick;
            add_a     <= req_a[FP_W*pick +: FP_W];
            add_b     <= req_b[FP_W*pick +: FP_W];
            req_ack   <= N_REQ'(1) << pick;
            add_a_stb <= 1'b1;
            add_b_stb <= 1'b1;
            busy      <= 1'b1;
            state     <= StSend;
          end
        end
        StSend: begin
          if (add_a_ack) add_a_stb <= 1'b0;
          if (add_b_ack) add_b_stb <= 1'b0;
          if (a_done && b_done) state <= StWaitZ;
        end
        StWaitZ: begin
          if (add_z_stb) begin
            resp_z    <= add_z;
            add_z_ack <= 1'b1;
            resp_stb  <= N_REQ'(1) << grant_id;
            state     <= StResp;
          end
        end
        StResp: begin
          // Only the granted line's ack counts; resp_stb is one-hot on it.
          if ((resp_ack & resp_stb) != '0) begin
            resp_stb <= '0;
            ptr      <= next_ptr;
            busy     <= 1'b0;
            state    <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_adder_arbiter.sv
// Self-checking bench: behavioural stb/ack adder, requesters and responder run
// in one negedge environment loop; expected (grant, z) pairs go to a queue.
module tb_fp_adder_arbiter;
  import fp_pkg::*;

  localparam int unsigned N   = 4;
  localparam int unsigned IDW = 2;

  logic              clk;
  logic              rst;
  logic [N-1:0]      req_stb;
  logic [N-1:0]      req_ack;
  logic [32*N-1:0]   req_a;
  logic [32*N-1:0]   req_b;
  logic [N-1:0]      resp_stb;
  logic [N-1:0]      resp_ack;
  logic [31:0]       resp_z;
  logic [31:0]       add_a;
  logic              add_a_stb;
  logic              add_a_ack;
  logic [31:0]       add_b;
  logic              add_b_stb;
  logic              add_b_ack;
  logic [31:0]       add_z;
  logic              add_z_stb;
  logic              add_z_ack;
  logic              busy;
  logic [IDW-1:0]    grant_id;

  fp_adder_arbiter #(
    .N_REQ (N),
    .IDW   (IDW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_stb   (req_stb),
    .req_ack   (req_ack),
    .req_a     (req_a),
    .req_b     (req_b),
    .resp_stb  (resp_stb),
    .resp_ack  (resp_ack),
    .resp_z    (resp_z),
    .add_a     (add_a),
    .add_a_stb (add_a_stb),
    .add_a_ack (add_a_ack),
    .add_b     (add_b),
    .add_b_stb (add_b_stb),
    .add_b_ack (add_b_ack),
    .add_z     (add_z),
    .add_z_stb (add_z_stb),
    .add_z_ack (add_z_ack),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [31:0] z;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Knobs written by the sequence, read by the environment.
  int a_dly = 0, b_dly = 0, lat = 2, resp_dly = 0;
  int req_want[N];
  // Written by the environment only.
  int req_got[N];
  int ack_cnt[N];
  int zack_cnt = 0;
  int cyc = 0;
  int a_drop = -1, b_drop = -1;
  logic [31:0] seen_a, seen_b;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  function automatic real f2r(input logic [31:0] x);
    logic [63:0] d;
    if (x[30:0] == 31'd0) return 0.0;
    d = {x[31], 11'(x[30:23]) - 11'd127 + 11'd1023, x[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [10:0] e;
    if (r == 0.0) return 32'd0;
    d = $realtobits(r);
    e = d[62:52];
    return {d[63], 8'(e - 11'd1023 + 11'd127), d[51:29]};
  endfunction

  function automatic logic [31:0] fadd(input logic [31:0] x, input logic [31:0] y);
    return r2f(f2r(x) + f2r(y));
  endfunction

  // Environment: requesters, adder model and responder, all at the negedge.
  initial begin
    int          m_st, m_cnt, r_wait, r_bad, id;
    logic        a_got, b_got, r_seen;
    logic [31:0] r_first;
    exp_t        e;
    m_st = 0; m_cnt = 0; r_wait = 0; r_bad = 0; a_got = 0; b_got = 0;
    r_seen = 0; r_first = '0;
    req_stb = '0; resp_ack = '0; add_a_ack = 0; add_b_ack = 0;
    add_z = '0; add_z_stb = 0; seen_a = '0; seen_b = '0;
    for (int i = 0; i < N; i++) begin req_got[i] = 0; ack_cnt[i] = 0; end
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        m_st = 0; add_a_ack = 0; add_b_ack = 0; add_z_stb = 0;
        resp_ack = '0; r_seen = 0;
        continue;
      end
      // Requesters: a capture consumes one outstanding request.
      for (int i = 0; i < N; i++) begin
        if (req_ack[i]) begin ack_cnt[i]++; req_got[i]++; end
        req_stb[i] = (req_want[i] > req_got[i]);
      end
      if (add_z_ack) zack_cnt++;
      // Adder model.
      add_a_ack = 0;
      add_b_ack = 0;
      if (m_st == 0 && add_a_stb && add_b_stb) begin
        seen_a = add_a; seen_b = add_b; m_cnt = 0;
        a_got = 0; b_got = 0; a_drop = -1; b_drop = -1; m_st = 1;
      end
      if (m_st == 1) begin
        if (!a_got && m_cnt == a_dly) begin add_a_ack = 1; a_got = 1; end
        else if (a_got && !add_a_stb && a_drop < 0) a_drop = cyc;
        if (!b_got && m_cnt == b_dly) begin add_b_ack = 1; b_got = 1; end
        else if (b_got && !add_b_stb && b_drop < 0) b_drop = cyc;
        m_cnt++;
        if (a_drop >= 0 && b_drop >= 0) begin m_st = 2; m_cnt = 0; end
      end else if (m_st == 3) begin
        if (add_z_ack) begin add_z_stb = 0; m_st = 0; end
      end else if (m_st == 2) begin
        if (m_cnt >= lat) begin
          add_z = fadd(seen_a, seen_b); add_z_stb = 1; m_st = 3;
        end else m_cnt++;
      end
      // Responder.
      if (resp_ack != '0) resp_ack = '0;
      else if (resp_stb != '0) begin
        if (!r_seen) begin r_seen = 1; r_first = resp_z; r_wait = 0; r_bad = 0; end
        else r_wait++;
        if (req_ack != '0 || !busy) r_bad++;
        if (r_wait >= resp_dly) begin
          resp_ack = resp_stb;
          r_seen   = 0;
          if (sb.size() == 0) check_eq("sb_extra", 32'(resp_stb), 32'd0);
          else begin
            e  = sb.pop_front();
            id = -1;
            if ($countones(resp_stb) == 1)
              for (int i = 0; i < N; i++) if (resp_stb[i]) id = i;
            check_eq("grant", id, e.id);
            check_eq("grant_id", 32'(grant_id), e.id);
            check_eq("resp_z", resp_z, e.z);
            check_eq("z_stable", resp_z, r_first);
            check_eq("stall_quiet", r_bad, 0);
          end
        end
      end
    end
  end

  task automatic issue(input int i, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] z);
    exp_t e;
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
    req_want[i]++;
    e.id = i;
    e.z  = z;
    sb.push_back(e);
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 3000 && sb.size() != 0; k++) @(negedge clk);
    check_eq({tag, "_drain"}, sb.size(), 0);
    repeat (3) @(negedge clk);
    check_eq({tag, "_idle"}, 32'(busy), 0);
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_busy"}, 32'(busy), 0);
    check_eq({tag, "_req_ack"}, 32'(req_ack), 0);
    check_eq({tag, "_resp_stb"}, 32'(resp_stb), 0);
    check_eq({tag, "_a_stb"}, 32'(add_a_stb), 0);
    check_eq({tag, "_b_stb"}, 32'(add_b_stb), 0);
    check_eq({tag, "_z_ack"}, 32'(add_z_ack), 0);
    check_eq({tag, "_grant_id"}, 32'(grant_id), 0);
    check_eq({tag, "_resp_z"}, resp_z, 0);
    check_eq({tag, "_add_a"}, add_a, 0);
    check_eq({tag, "_add_b"}, add_b, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int z0, ack0, found;
    rst   = 1'b0;
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < N; i++) req_want[i] = 0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Single request on line 0.
    ack0 = ack_cnt[0];
    issue(0, FP_ONE, FP_TWO, FP_THREE);
    drain("single");
    check_eq("single_seen_a", seen_a, FP_ONE);
    check_eq("single_seen_b", seen_b, FP_TWO);
    check_eq("single_ack_once", ack_cnt[0] - ack0, 1);

    // ptr is now 1, so line 1 beats line 0.
    issue(1, 32'h4080_0000, 32'hBF80_0000, FP_THREE);
    issue(0, 32'h3F00_0000, 32'h3E80_0000, 32'h3F40_0000);
    drain("ptr1");

    // Reset while idle returns ptr to 0.
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);

    // All four at once from ptr 0.
    z0 = zack_cnt;
    issue(0, FP_ONE, FP_TWO, FP_THREE);
    issue(1, 32'h3F00_0000, 32'h3E80_0000, 32'h3F40_0000);
    issue(2, 32'h4080_0000, 32'hBF80_0000, FP_THREE);
    issue(3, FP_TWO, FP_TWO, 32'h4080_0000);
    drain("all4");
    check_eq("all4_zack", zack_cnt - z0, 4);

    // Fairness: line 1 holds for two captures, line 3 asks once.
    issue(1, FP_ONE, FP_ONE, FP_TWO);
    issue(3, FP_TWO, FP_ONE, FP_THREE);
    issue(1, FP_ONE, FP_ONE, FP_TWO);
    drain("fair");

    // Ack skew: b acked three cycles before a.
    a_dly = 3; b_dly = 0;
    z0 = zack_cnt;
    issue(2, FP_ONE, FP_ONE, FP_TWO);
    drain("skew");
    check_eq("skew_drop_gap", a_drop - b_drop, 3);
    check_eq("skew_zack", zack_cnt - z0, 1);
    a_dly = 0;

    // Response back-pressure with a competing request arriving in RESP.
    resp_dly = 10;
    issue(0, FP_ONE, FP_ONE, FP_TWO);
    found = 0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge clk);
      if (resp_stb != '0) found = 1;
    end
    check_eq("bp_resp_seen", found, 1);
    issue(3, FP_THREE, FP_ONE, 32'h4080_0000);
    drain("bp");
    resp_dly = 0;

    // Reset in WAIT_Z abandons the operation.
    lat = 20;
    issue(1, FP_TWO, FP_TWO, 32'h4080_0000);
    found = 0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge clk);
      if (busy && !add_a_stb && !add_b_stb && resp_stb == '0) found = 1;
    end
    check_eq("mid_reach_waitz", found, 1);
    repeat (3) @(negedge clk);
    check_eq("mid_pre_grant", 32'(grant_id), 1);
    #2 rst = 1'b0;
    #1 check_zero("mid_rst");
    sb.delete();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    lat = 2;
    @(negedge clk);
    issue(2, FP_ONE, FP_TWO, FP_THREE);
    drain("post_rst");
    // ptr is 3 after serving 2, so 3 goes before 0.
    issue(3, FP_ONE, FP_ONE, FP_TWO);
    issue(0, FP_TWO, FP_ONE, FP_THREE);
    drain("post_ptr");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
